// File: rtl/dm_arbiter_if.sv
// Port bundle for dm_arbiter: two requester ports plus the data-memory side.
// slave = the arbiter's view, master = the requesters/memory environment.
interface dm_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              p0_req;
    logic              p0_we;
    logic [ADDR_W-1:0] p0_addr;
    logic [DATA_W-1:0] p0_wdata;
    logic              p0_gnt;
    logic              p0_rvalid;
    logic [DATA_W-1:0] p0_rdata;

    logic              p1_req;
    logic              p1_we;
    logic [ADDR_W-1:0] p1_addr;
    logic [DATA_W-1:0] p1_wdata;
    logic              p1_gnt;
    logic              p1_rvalid;
    logic [DATA_W-1:0] p1_rdata;

    logic [ADDR_W-1:0] dm_addr;
    logic              dm_re;
    logic              dm_we;
    logic [DATA_W-1:0] dm_wrt_data;
    logic [DATA_W-1:0] dm_rd_data;

    modport slave (
        input  p0_req, p0_we, p0_addr, p0_wdata,
        input  p1_req, p1_we, p1_addr, p1_wdata,
        input  dm_rd_data,
        output p0_gnt, p0_rvalid, p0_rdata,
        output p1_gnt, p1_rvalid, p1_rdata,
        output dm_addr, dm_re, dm_we, dm_wrt_data
    );

    modport master (
        output p0_req, p0_we, p0_addr, p0_wdata,
        output p1_req, p1_we, p1_addr, p1_wdata,
        output dm_rd_data,
        input  p0_gnt, p0_rvalid, p0_rdata,
        input  p1_gnt, p1_rvalid, p1_rdata,
        input  dm_addr, dm_re, dm_we, dm_wrt_data
    );
endinterface

// File: rtl/dm_arbiter.sv
// dm_arbiter: two-port arbiter in front of a single-port data memory.
// Define DM_ARB_RR_EN for round-robin tie-break; default is fixed priority to port 0.
//
// state | meaning
// IDLE  | no port granted this cycle
// GNT0  | port 0 granted for this one cycle
// GNT1  | port 1 granted for this one cycle
module dm_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input logic         clk,
    input logic         rst_n,
    dm_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              gnt0;
    logic              gnt1;
    logic              xfer0;
    logic              xfer1;
    logic              prio_nxt;
    logic              rvalid0;
    logic              rvalid1;
    logic [DATA_W-1:0] rdata0;
    logic [DATA_W-1:0] rdata1;
    logic [ADDR_W-1:0] addr_sel;
    logic [DATA_W-1:0] wdata_sel;

`ifdef DM_ARB_RR_EN
    logic prio;  // port that wins the next tie

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) prio <= 1'b0;
        else        prio <= prio_nxt;
    end

    // A transfer finishing this cycle already counts, so held requests alternate.
    assign prio_nxt = xfer0 ? 1'b1 : (xfer1 ? 1'b0 : prio);
`else
    assign prio_nxt = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = IDLE;
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        case (state)
            GNT0:    gnt0 = 1'b1;
            GNT1:    gnt1 = 1'b1;
            default: ;
        endcase
        case ({bus.p1_req, bus.p0_req})
            2'b01:   state_nxt = GNT0;
            2'b10:   state_nxt = GNT1;
            2'b11:   state_nxt = prio_nxt ? GNT1 : GNT0;
            default: state_nxt = IDLE;
        endcase
    end

    assign xfer0 = gnt0 & bus.p0_req;
    assign xfer1 = gnt1 & bus.p1_req;

    assign addr_sel  = gnt1 ? bus.p1_addr  : bus.p0_addr;
    assign wdata_sel = gnt1 ? bus.p1_wdata : bus.p0_wdata;

    assign bus.p0_gnt      = gnt0;
    assign bus.p1_gnt      = gnt1;
    assign bus.dm_addr     = addr_sel;
    assign bus.dm_wrt_data = wdata_sel;
    assign bus.dm_we       = (xfer0 & bus.p0_we) | (xfer1 & bus.p1_we);
    assign bus.dm_re       = (xfer0 & ~bus.p0_we) | (xfer1 & ~bus.p1_we);

    // Memory drives dm_rd_data off the falling edge, so it is stable here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            rdata0  <= '0;
            rdata1  <= '0;
        end else begin
            rvalid0 <= xfer0 & ~bus.p0_we;
            rvalid1 <= xfer1 & ~bus.p1_we;
            if (xfer0 & ~bus.p0_we) rdata0 <= bus.dm_rd_data;
            if (xfer1 & ~bus.p1_we) rdata1 <= bus.dm_rd_data;
        end
    end

    assign bus.p0_rvalid = rvalid0;
    assign bus.p1_rvalid = rvalid1;
    assign bus.p0_rdata  = rdata0;
    assign bus.p1_rdata  = rdata1;
endmodule

// File: tb/tb_dm_arbiter.sv
// Self-checking bench for dm_arbiter: directed scenarios then random traffic,
// all checked against a cycle-level reference model and a falling-edge memory.
module tb_dm_arbiter;
    localparam int AW = 16;
    localparam int DW = 16;
`ifdef DM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dm_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
    dm_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    logic          req   [2];
    logic          we    [2];
    logic [AW-1:0] addr  [2];
    logic [DW-1:0] wdata [2];

    assign bus.p0_req   = req[0];
    assign bus.p0_we    = we[0];
    assign bus.p0_addr  = addr[0];
    assign bus.p0_wdata = wdata[0];
    assign bus.p1_req   = req[1];
    assign bus.p1_we    = we[1];
    assign bus.p1_addr  = addr[1];
    assign bus.p1_wdata = wdata[1];

    function automatic logic [DW-1:0] init_val(int a);
        if (a == 1) return 16'h1111;
        if (a == 2) return 16'h2222;
        return DW'(a * 16'h0101) ^ 16'hA5C3;
    endfunction

    // data memory environment: writes and read flop on the falling edge
    logic [DW-1:0] mem [int];
    always @(negedge clk) begin
        if (bus.dm_re)
            bus.dm_rd_data <= mem.exists(int'(bus.dm_addr)) ? mem[int'(bus.dm_addr)]
                                                          : init_val(int'(bus.dm_addr));
        if (bus.dm_we) mem[int'(bus.dm_addr)] = bus.dm_wrt_data;
    end

    // reference model: who holds the grant this cycle, what each port should see
    int            m_gp = -1;
    bit            m_prio = 1'b0;
    bit            m_rv   [2] = '{1'b0, 1'b0};
    logic [DW-1:0] m_rd   [2] = '{16'h0, 16'h0};
    bit            m_last [2] = '{1'b0, 1'b0};
    logic [DW-1:0] m_mem  [int];

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] m_read(int a);
        return m_mem.exists(a) ? m_mem[a] : init_val(a);
    endfunction

    function automatic void model_step();
        m_rv   = '{1'b0, 1'b0};
        m_last = '{1'b0, 1'b0};
        if (m_gp >= 0 && req[m_gp]) begin
            m_last[m_gp] = 1'b1;
            if (we[m_gp]) m_mem[int'(addr[m_gp])] = wdata[m_gp];
            else begin
                m_rv[m_gp] = 1'b1;
                m_rd[m_gp] = m_read(int'(addr[m_gp]));
            end
            m_prio = (m_gp == 0);
        end
        if (req[0] && req[1]) m_gp = RR ? int'(m_prio) : 0;
        else if (req[0])      m_gp = 0;
        else if (req[1])      m_gp = 1;
        else                  m_gp = -1;
    endfunction

    task automatic reset_now();
        rst_n  = 1'b0;
        m_gp   = -1;
        m_prio = 1'b0;
        m_rv   = '{1'b0, 1'b0};
        m_rd   = '{16'h0, 16'h0};
        m_last = '{1'b0, 1'b0};
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_step();
        else m_last = '{1'b0, 1'b0};
        #1;
    endtask

    task automatic check_cycle();
        int  gi;
        bit  xfer;
        @(negedge clk);
        gi   = (m_gp < 0) ? 0 : m_gp;
        xfer = (m_gp >= 0) && req[gi];
        check("p0_gnt", bus.p0_gnt, m_gp == 0);
        check("p1_gnt", bus.p1_gnt, m_gp == 1);
        check("dm_we", bus.dm_we, xfer && we[gi]);
        check("dm_re", bus.dm_re, xfer && !we[gi]);
        if (xfer) begin
            check("dm_addr", bus.dm_addr, addr[gi]);
            if (we[gi]) check("dm_wrt_data", bus.dm_wrt_data, wdata[gi]);
        end
        check("p0_rvalid", bus.p0_rvalid, m_rv[0]);
        check("p1_rvalid", bus.p1_rvalid, m_rv[1]);
        check("p0_rdata", bus.p0_rdata, m_rd[0]);
        check("p1_rdata", bus.p1_rdata, m_rd[1]);
        check("re_we_excl", bus.dm_re & bus.dm_we, 0);
        check("gnt_excl", bus.p0_gnt & bus.p1_gnt, 0);
    endtask

    task automatic set_port(int p, logic r, logic w, logic [AW-1:0] a, logic [DW-1:0] d);
        req[p]   = r;
        we[p]    = w;
        addr[p]  = a;
        wdata[p] = d;
    endtask

    task automatic do_reset();
        set_port(0, 1'b0, 1'b0, '0, '0);
        set_port(1, 1'b0, 1'b0, '0, '0);
        reset_now();
        tick();
        check_cycle();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        int c0;
        int c1;
        set_port(0, 1'b0, 1'b0, '0, '0);
        set_port(1, 1'b0, 1'b0, '0, '0);
        reset_now();
        tick();
        check_cycle();
        check("rst_p0_rdata", bus.p0_rdata, 0);
        rst_n = 1'b1;
        tick();

        // p0 write BEEF @0x10, idle, then read it back
        set_port(0, 1'b1, 1'b1, 16'h0010, 16'hBEEF);
        check_cycle(); check("wr_gnt_c0", bus.p0_gnt, 0); tick();
        check_cycle(); check("wr_gnt_c1", bus.p0_gnt, 1); tick();
        set_port(0, 1'b0, 1'b0, 16'h0010, '0);
        check_cycle(); tick();
        set_port(0, 1'b1, 1'b0, 16'h0010, '0);
        check_cycle(); check("rd_gnt_c0", bus.p0_gnt, 0); tick();
        check_cycle(); check("rd_gnt_c1", bus.p0_gnt, 1); tick();
        set_port(0, 1'b0, 1'b0, 16'h0010, '0);
        check_cycle(); check("rd_rvalid_c2", bus.p0_rvalid, 1);
        check("rd_rdata_c2", bus.p0_rdata, 16'hBEEF); tick();
        check_cycle(); check("rd_rvalid_c3", bus.p0_rvalid, 0);
        check("rd_hold_c3", bus.p0_rdata, 16'hBEEF); tick();

        // both ports hold reads: alternate (RR) or p0 starves p1 (fixed)
        do_reset();
        set_port(0, 1'b1, 1'b0, 16'h0001, '0);
        set_port(1, 1'b1, 1'b0, 16'h0002, '0);
        check_cycle(); tick();
        for (int i = 0; i < 4; i++) begin
            check_cycle();
            check("both_p0_gnt", bus.p0_gnt, RR ? (i % 2 == 0) : 1'b1);
            check("both_p1_gnt", bus.p1_gnt, RR ? (i % 2 == 1) : 1'b0);
            tick();
        end
        req[0] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check_cycle();
            if (bus.p1_gnt) break;
            tick();
        end
        check("p1_unstarved", bus.p1_gnt, 1);
        tick();
        req[1] = 1'b0;
        check_cycle(); tick();
        check_cycle(); tick();

        // p0 reads 0x1 and p1 reads 0x2: each rvalid goes to its own port
        do_reset();
        set_port(0, 1'b1, 1'b0, 16'h0001, '0);
        set_port(1, 1'b1, 1'b0, 16'h0002, '0);
        c0 = -1;
        c1 = -1;
        for (int c = 0; c < 10; c++) begin
            check_cycle();
            if (bus.p0_rvalid && c0 < 0) begin
                c0 = c;
                check("x_p0_data", bus.p0_rdata, 16'h1111);
            end
            if (bus.p1_rvalid && c1 < 0) begin
                c1 = c;
                check("x_p1_data", bus.p1_rdata, 16'h2222);
            end
            tick();
            for (int p = 0; p < 2; p++) if (m_last[p]) req[p] = 1'b0;
        end
        check("x_p0_seen", c0 >= 0, 1);
        check("x_p1_seen", c1 >= 0, 1);
        check("x_gap", c1 - c0, RR ? 1 : 2);

        // reset in a read's grant cycle
        do_reset();
        set_port(0, 1'b1, 1'b1, 16'h0003, 16'h3333);
        check_cycle(); tick();
        check_cycle(); tick();
        req[0] = 1'b0;
        check_cycle(); tick();
        set_port(0, 1'b1, 1'b0, 16'h0001, '0);
        check_cycle(); tick();
        check_cycle(); check("rst_mid_gnt", bus.p0_gnt, 1);
        reset_now();
        #1;
        check("rst_mid_gnt_low", bus.p0_gnt, 0);
        check("rst_mid_re_low", bus.dm_re, 0);
        set_port(1, 1'b1, 1'b0, 16'h0002, '0);
        tick();
        check_cycle();
        check("rst_no_rvalid", bus.p0_rvalid, 0);
        rst_n = 1'b1;
        tick();
        check_cycle();
        check("rst_first_p0", bus.p0_gnt, 1);
        check("rst_first_p1", bus.p1_gnt, 0);
        tick();
        set_port(0, 1'b0, 1'b0, '0, '0);
        set_port(1, 1'b0, 1'b0, '0, '0);
        check_cycle(); tick();
        check_cycle(); tick();

        // random traffic obeying the hold-until-transfer rule
        for (int n = 0; n < 3000; n++) begin
            check_cycle();
            tick();
            for (int p = 0; p < 2; p++) begin
                if (!req[p] || m_last[p]) begin
                    if ($urandom_range(99) < 60)
                        set_port(p, 1'b1, 1'($urandom_range(1)), AW'($urandom_range(15)),
                                 DW'($urandom));
                    else
                        req[p] = 1'b0;
                end
            end
        end
        set_port(0, 1'b0, 1'b0, '0, '0);
        set_port(1, 1'b0, 1'b0, '0, '0);
        for (int n = 0; n < 3; n++) begin
            check_cycle();
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/dm_arbiter.md
DM_ARBITER -- requirements
Module: dm_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, address width of each port and of the memory.
REQ-002 SHALL have parameter DATA_W, default 16, data width of each port and of the memory.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; every flop is posedge clk.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have ports p0_req, p1_req, input, 1 bit each: access request (p0 = CPU, p1 = DMA/boot loader).
REQ-006 SHALL have ports p0_we, p1_we, input, 1 bit each: 1 = write, 0 = read.
REQ-007 SHALL have ports p0_addr, p1_addr, input, ADDR_W each: word address.
REQ-008 SHALL have ports p0_wdata, p1_wdata, input, DATA_W each: write data.
REQ-009 SHALL have ports p0_gnt, p1_gnt, output, 1 bit each: access accepted this cycle.
REQ-010 SHALL have ports p0_rvalid, p1_rvalid, output, 1 bit each: read data valid.
REQ-011 SHALL have ports p0_rdata, p1_rdata, output, DATA_W each: read data.
REQ-012 SHALL have ports dm_addr (ADDR_W), dm_re (1), dm_we (1) and dm_wrt_data (DATA_W), all outputs, driving the data memory.
REQ-013 SHALL have port dm_rd_data, input, DATA_W: memory read data, flopped by the memory on negedge clk.

Function
REQ-014 SHALL implement a state machine with states IDLE, GNT0 and GNT1; each GNTx state lasts exactly one cycle.
REQ-015 SHALL compute the next state on every posedge from p0_req, p1_req and the priority rule (REQ-025/REQ-026): no request -> IDLE; one request -> GNT of that port; both -> GNT of the winning port.
REQ-016 SHALL assert pX_gnt = 1 combinationally from state GNTx only; both grants SHALL never be 1 together.
REQ-017 SHALL treat pX_req && pX_gnt as the transfer; the requester SHALL hold req, we, addr and wdata stable until the transfer and may keep req high for a new back-to-back access.
REQ-018 SHALL, during a transfer, drive dm_addr = pX_addr, dm_wrt_data = pX_wdata, dm_we = pX_we and dm_re = ~pX_we; dm_re and dm_we SHALL never be 1 together.
REQ-019 SHALL hold dm_re = dm_we = 0 in IDLE and in a GNTx cycle whose pX_req is low (protocol violation: no access, no rvalid).
REQ-020 SHALL, for a read transfer in cycle N, register dm_rd_data at the posedge ending cycle N and present it on pX_rdata with pX_rvalid = 1 for exactly cycle N+1.
REQ-021 SHALL hold pX_rdata at its last captured value while pX_rvalid = 0; a write transfer SHALL produce no rvalid.
REQ-022 SHALL give a minimum latency of req asserted in cycle N -> gnt in N+1 -> rvalid in N+2, with a peak throughput of one access per cycle across both ports.
REQ-023 SHALL allow back-to-back reads from different ports; each rvalid SHALL go only to the port that issued the read.

Reset
REQ-024 SHALL, while rst_n = 0 (asserted at any time, including mid-transfer), force state IDLE, p0_gnt = p1_gnt = 0, p0_rvalid = p1_rvalid = 0, p0_rdata = p1_rdata = 0, dm_re = dm_we = 0 and the priority pointer to port 0; any in-flight read SHALL be discarded.

Configuration
REQ-025 SHALL, with macro DM_ARB_RR_EN defined, resolve simultaneous requests round-robin: a 1-bit last-granted pointer, the port not granted last wins, and the pointer updates on every transfer.
REQ-026 SHALL, with DM_ARB_RR_EN undefined, use fixed priority: port 0 always wins, and the pointer logic is absent.

Verification
REQ-027 SHALL cover: after reset, p0 writes 0xBEEF to 0x0010, then reads 0x0010 -> p0_gnt in cycle 1 after req, p0_rvalid with p0_rdata = 0xBEEF exactly 2 cycles after the read req.
REQ-028 SHALL cover: p0 and p1 both hold reads for 4 cycles with DM_ARB_RR_EN defined -> grants alternate p0,p1,p0,p1; without the macro -> p0 granted every cycle and p1 starved until p0_req drops.
REQ-029 SHALL cover: p0 reads 0x0001 (=0x1111) then p1 reads 0x0002 (=0x2222) in consecutive cycles -> p0_rvalid/0x1111 then p1_rvalid/0x2222 in consecutive cycles, with no cross-delivery.
REQ-030 SHALL cover: rst_n pulled low in a read's grant cycle -> no rvalid afterwards, all outputs 0, and the first request after release is granted to p0.
REQ-031 SHALL cover: continuous check -> never dm_re && dm_we, never both gnt, and dm_we = 1 only in a transfer cycle of a write.
